fx3_slfifo_responder: RTL and testbench

- Synthesizable model of the FX3 side of the synchronous slave-FIFO (GPIF) interface. The FPGA-side `dut` is the master.
- It responds to SL_CS_N, SL_RD_N, SL_WR_N, SL_OE_N, SL_PKTEND_N and SL_AD, and drives SL_DT and SL_FLAGA..D.
- It bridges to host-side valid/ready streams through two internal buffers: U2F (host-to-FPGA) and F2U (FPGA-to-host).
- Used for loopback boards and FPGA-to-FPGA emulation without an FX3 device.

---
 rtl/fx3_slfifo_responder.sv | 211 +++++++++++++++++++++
 tb/tb_fx3_slfifo_responder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fx3_slfifo_responder.sv
// fx3_slfifo_responder
//
// Synthesizable stand-in for the FX3 side of the synchronous slave-FIFO
// (GPIF) interface. The FPGA master reads the U2F buffer (filled by the host
// stream) and writes the F2U buffer (drained by the host stream).
//
// Ports:
//   SYS_CLK, SYS_RST           single clock, synchronous active-high reset
//   SL_CS_N/RD_N/WR_N/OE_N     slave-FIFO strobes from the master, active low
//   SL_PKTEND_N                packet end, active low (alone = ZLP)
//   SL_AD[1:0]                 socket select: 00 = U2F, 01 = F2U
//   SL_DT_I / SL_DT_O / SL_DT_T  data bus in / out / drive-enable
//   SL_FLAGA..D                registered U2F/F2U status flags
//   HU2F_*                     host push stream into U2F (valid/ready)
//   HF2U_*                     host pop stream out of F2U (first-word-fall-through)
//   ERR_UNDERRUN, ERR_OVERRUN  sticky protocol errors, cleared by reset only
//
// Optional build macro FX3_SLFIFO_STAT_EN adds the STAT_* traffic counters.
module fx3_slfifo_responder #(
  parameter int DEPTH_U2F  = 1024,
  parameter int DEPTH_F2U  = 1024,
  parameter int RD_LATENCY = 2,
  parameter int FLAG_WM    = 4
) (
  input  logic        SYS_CLK,
  input  logic        SYS_RST,
  input  logic        SL_CS_N,
  input  logic        SL_RD_N,
  input  logic        SL_WR_N,
  input  logic        SL_OE_N,
  input  logic        SL_PKTEND_N,
  input  logic [1:0]  SL_AD,
  input  logic [31:0] SL_DT_I,
  output logic [31:0] SL_DT_O,
  output logic        SL_DT_T,
  output logic        SL_FLAGA,
  output logic        SL_FLAGB,
  output logic        SL_FLAGC,
  output logic        SL_FLAGD,
  input  logic        HU2F_VALID,
  output logic        HU2F_READY,
  input  logic [31:0] HU2F_DATA,
  output logic        HF2U_VALID,
  input  logic        HF2U_READY,
  output logic [31:0] HF2U_DATA,
  output logic        HF2U_LAST,
  output logic        HF2U_ZLP,
  output logic        ERR_UNDERRUN,
  output logic        ERR_OVERRUN
`ifdef FX3_SLFIFO_STAT_EN
  ,
  output logic [31:0] STAT_U2F_WORDS,
  output logic [31:0] STAT_F2U_WORDS,
  output logic [31:0] STAT_F2U_PKTS
`endif
);

  localparam int UAW = $clog2(DEPTH_U2F);
  localparam int FAW = $clog2(DEPTH_F2U);
  localparam logic [UAW:0]   U2F_FULL = (UAW+1)'(DEPTH_U2F);
  localparam logic [FAW:0]   F2U_FULL = (FAW+1)'(DEPTH_F2U);
  localparam logic [UAW:0]   U2F_ONE  = (UAW+1)'(1);
  localparam logic [FAW:0]   F2U_ONE  = (FAW+1)'(1);
  localparam logic [UAW-1:0] UPTR_ONE = UAW'(1);
  localparam logic [FAW-1:0] FPTR_ONE = FAW'(1);

  // U2F buffer state
  logic [31:0]    r_u2f_mem [DEPTH_U2F];
  logic [UAW-1:0] r_u2f_wptr, r_u2f_rptr;
  logic [UAW:0]   r_u2f_cnt, w_u2f_cnt_nxt;
  logic           w_u2f_full, w_u2f_empty;
  logic           w_sl_rd, w_u2f_pop, w_host_push;
  logic [31:0]    w_u2f_rdata;

  // F2U buffer state; entries are {zlp, last, data}
  logic [33:0]    r_f2u_mem [DEPTH_F2U];
  logic [FAW-1:0] r_f2u_wptr, r_f2u_rptr;
  logic [FAW:0]   r_f2u_cnt, w_f2u_cnt_nxt;
  logic           w_f2u_full, w_f2u_empty;
  logic           w_sl_wr, w_sl_pe, w_f2u_req, w_f2u_push, w_host_pop;
  logic [33:0]    w_f2u_entry, w_f2u_head;

  // Read pipeline and registered outputs
  logic [RD_LATENCY-1:0] r_pipe_v;
  logic [31:0]           r_pipe_d [RD_LATENCY];
  logic [31:0]           r_dt_hold;
  logic                  r_dt_t;
  logic                  r_flaga, r_flagb, r_flagc, r_flagd;
  logic                  r_err_under, r_err_over;

  assign w_u2f_full  = (r_u2f_cnt == U2F_FULL);
  assign w_u2f_empty = (r_u2f_cnt == '0);
  assign w_f2u_full  = (r_f2u_cnt == F2U_FULL);
  assign w_f2u_empty = (r_f2u_cnt == '0);

  // Strobe decode: each strobe only acts on its own socket address
  assign w_sl_rd   = ~SL_CS_N & ~SL_RD_N & (SL_AD == 2'b00);
  assign w_sl_wr   = ~SL_CS_N & ~SL_WR_N & (SL_AD == 2'b01);
  assign w_sl_pe   = ~SL_CS_N & ~SL_PKTEND_N & SL_WR_N & (SL_AD == 2'b01);
  assign w_f2u_req = w_sl_wr | w_sl_pe;

  assign w_u2f_pop  = w_sl_rd & ~w_u2f_empty;
  assign w_f2u_push = w_f2u_req & ~w_f2u_full;

  // READY is held low while reset is asserted so no push is lost to the clear
  assign HU2F_READY  = ~SYS_RST & ~w_u2f_full;
  assign w_host_push = HU2F_VALID & HU2F_READY;

  assign w_u2f_rdata = r_u2f_mem[r_u2f_rptr];
  assign w_f2u_entry = w_sl_wr ? {1'b0, ~SL_PKTEND_N, SL_DT_I} : {2'b11, 32'h0};
  assign w_f2u_head  = r_f2u_mem[r_f2u_rptr];

  assign HF2U_VALID = ~w_f2u_empty;
  assign w_host_pop = HF2U_VALID & HF2U_READY;
  assign HF2U_DATA  = HF2U_VALID ? w_f2u_head[31:0] : 32'h0;
  assign HF2U_LAST  = HF2U_VALID & w_f2u_head[32];
  assign HF2U_ZLP   = HF2U_VALID & w_f2u_head[33];

  // Next counts feed the registered flags so they reflect the post-update level
  always_comb begin
    w_u2f_cnt_nxt = r_u2f_cnt;
    if (w_host_push && !w_u2f_pop)      w_u2f_cnt_nxt = r_u2f_cnt + U2F_ONE;
    else if (!w_host_push && w_u2f_pop) w_u2f_cnt_nxt = r_u2f_cnt - U2F_ONE;
    w_f2u_cnt_nxt = r_f2u_cnt;
    if (w_f2u_push && !w_host_pop)      w_f2u_cnt_nxt = r_f2u_cnt + F2U_ONE;
    else if (!w_f2u_push && w_host_pop) w_f2u_cnt_nxt = r_f2u_cnt - F2U_ONE;
  end

  // Buffer storage is never reset; pointers and counts define what is valid
  always_ff @(posedge SYS_CLK) begin
    if (w_host_push) r_u2f_mem[r_u2f_wptr] <= HU2F_DATA;
    if (w_f2u_push)  r_f2u_mem[r_f2u_wptr] <= w_f2u_entry;
  end

  // Pointers, counts, flags and sticky errors
  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      r_u2f_wptr  <= '0;
      r_u2f_rptr  <= '0;
      r_u2f_cnt   <= '0;
      r_f2u_wptr  <= '0;
      r_f2u_rptr  <= '0;
      r_f2u_cnt   <= '0;
      r_flaga     <= 1'b0;
      r_flagb     <= 1'b0;
      r_flagc     <= 1'b1;
      r_flagd     <= 1'b1;
      r_err_under <= 1'b0;
      r_err_over  <= 1'b0;
      r_dt_t      <= 1'b0;
    end else begin
      if (w_host_push) r_u2f_wptr <= r_u2f_wptr + UPTR_ONE;
      if (w_u2f_pop)   r_u2f_rptr <= r_u2f_rptr + UPTR_ONE;
      if (w_f2u_push)  r_f2u_wptr <= r_f2u_wptr + FPTR_ONE;
      if (w_host_pop)  r_f2u_rptr <= r_f2u_rptr + FPTR_ONE;
      r_u2f_cnt <= w_u2f_cnt_nxt;
      r_f2u_cnt <= w_f2u_cnt_nxt;
      r_flaga   <= (w_u2f_cnt_nxt != '0);
      r_flagb   <= 32'(w_u2f_cnt_nxt) > 32'(FLAG_WM);
      r_flagc   <= (w_f2u_cnt_nxt != F2U_FULL);
      r_flagd   <= (32'(DEPTH_F2U) - 32'(w_f2u_cnt_nxt)) > 32'(FLAG_WM);
      if (w_sl_rd && w_u2f_empty)  r_err_under <= 1'b1;
      if (w_f2u_req && w_f2u_full) r_err_over  <= 1'b1;
      r_dt_t <= ~SL_CS_N & ~SL_OE_N & (SL_AD == 2'b00);
    end
  end

  // Read pipeline valid bits; the last stage drives SL_DT_O directly, so a
  // pop in cycle n shows on the bus in cycle n+RD_LATENCY
  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      r_pipe_v  <= '0;
      r_dt_hold <= 32'h0;
    end else begin
      r_pipe_v[0] <= w_u2f_pop;
      for (int i = 1; i < RD_LATENCY; i++) r_pipe_v[i] <= r_pipe_v[i-1];
      r_dt_hold <= SL_DT_O;
    end
  end

  always_ff @(posedge SYS_CLK) begin
    r_pipe_d[0] <= w_u2f_rdata;
    for (int i = 1; i < RD_LATENCY; i++) r_pipe_d[i] <= r_pipe_d[i-1];
  end

  assign SL_DT_O = r_pipe_v[RD_LATENCY-1] ? r_pipe_d[RD_LATENCY-1] : r_dt_hold;
  assign SL_DT_T = r_dt_t;
  assign SL_FLAGA = r_flaga;
  assign SL_FLAGB = r_flagb;
  assign SL_FLAGC = r_flagc;
  assign SL_FLAGD = r_flagd;
  assign ERR_UNDERRUN = r_err_under;
  assign ERR_OVERRUN  = r_err_over;

`ifdef FX3_SLFIFO_STAT_EN
  // Traffic counters; F2U words count data writes only, packets count every
  // pushed entry carrying last (ZLPs included)
  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      STAT_U2F_WORDS <= 32'h0;
      STAT_F2U_WORDS <= 32'h0;
      STAT_F2U_PKTS  <= 32'h0;
    end else begin
      if (w_u2f_pop)                  STAT_U2F_WORDS <= STAT_U2F_WORDS + 32'd1;
      if (w_f2u_push && w_sl_wr)      STAT_F2U_WORDS <= STAT_F2U_WORDS + 32'd1;
      if (w_f2u_push && w_f2u_entry[32]) STAT_F2U_PKTS <= STAT_F2U_PKTS + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fx3_slfifo_responder.sv
// tb_fx3_slfifo_responder
//
// Directed bench for fx3_slfifo_responder. Expected read data and expected
// F2U entries are queued as stimulus is issued; monitors pop and compare when
// the DUT presents them. Flags and error bits are checked inline.
module tb_fx3_slfifo_responder;

  localparam int DU  = 8;
  localparam int DF  = 4;
  localparam int RDL = 2;
  localparam int WM  = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        SL_CS_N, SL_RD_N, SL_WR_N, SL_OE_N, SL_PKTEND_N;
  logic [1:0]  SL_AD;
  logic [31:0] SL_DT_I, SL_DT_O;
  logic        SL_DT_T, SL_FLAGA, SL_FLAGB, SL_FLAGC, SL_FLAGD;
  logic        HU2F_VALID, HU2F_READY;
  logic [31:0] HU2F_DATA;
  logic        HF2U_VALID, HF2U_READY, HF2U_LAST, HF2U_ZLP;
  logic [31:0] HF2U_DATA;
  logic        ERR_UNDERRUN, ERR_OVERRUN;

  int          nTests = 0;
  int          nFail  = 0;
  int          f2uPops = 0;
  int          popsBefore;
  logic [31:0] rdExpQ[$];
  logic [33:0] f2uExpQ[$];
  bit          expectPop = 1'b0;
  bit [RDL-1:0] tbPipe = '0;

  always #5 clk = ~clk;

  fx3_slfifo_responder #(
    .DEPTH_U2F(DU), .DEPTH_F2U(DF), .RD_LATENCY(RDL), .FLAG_WM(WM)
  ) dut (
    .SYS_CLK(clk), .SYS_RST(rst),
    .SL_CS_N(SL_CS_N), .SL_RD_N(SL_RD_N), .SL_WR_N(SL_WR_N), .SL_OE_N(SL_OE_N),
    .SL_PKTEND_N(SL_PKTEND_N), .SL_AD(SL_AD), .SL_DT_I(SL_DT_I),
    .SL_DT_O(SL_DT_O), .SL_DT_T(SL_DT_T),
    .SL_FLAGA(SL_FLAGA), .SL_FLAGB(SL_FLAGB), .SL_FLAGC(SL_FLAGC), .SL_FLAGD(SL_FLAGD),
    .HU2F_VALID(HU2F_VALID), .HU2F_READY(HU2F_READY), .HU2F_DATA(HU2F_DATA),
    .HF2U_VALID(HF2U_VALID), .HF2U_READY(HF2U_READY), .HF2U_DATA(HF2U_DATA),
    .HF2U_LAST(HF2U_LAST), .HF2U_ZLP(HF2U_ZLP),
    .ERR_UNDERRUN(ERR_UNDERRUN), .ERR_OVERRUN(ERR_OVERRUN)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one bus cycle and returns just after the edge that sampled it
  task automatic applyStimulus(input logic cs_n, input logic rd_n, input logic wr_n,
                               input logic oe_n, input logic pe_n, input logic [1:0] ad,
                               input logic [31:0] dt, input bit pop);
    SL_CS_N = cs_n; SL_RD_N = rd_n; SL_WR_N = wr_n; SL_OE_N = oe_n;
    SL_PKTEND_N = pe_n; SL_AD = ad; SL_DT_I = dt; expectPop = pop;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 32'h0, 1'b0);
  endtask

  task automatic hostPush(input logic [31:0] d);
    HU2F_VALID = 1'b1;
    HU2F_DATA  = d;
    idle(1);
    HU2F_VALID = 1'b0;
  endtask

  task automatic readCycle(input bit pop, input logic [31:0] d, input logic oe_n);
    if (pop) rdExpQ.push_back(d);
    applyStimulus(1'b0, 1'b0, 1'b1, oe_n, 1'b1, 2'b00, 32'h0, pop);
  endtask

  task automatic writeCycle(input logic [31:0] d, input logic last, input bit acc);
    if (acc) f2uExpQ.push_back({1'b0, last, d});
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, ~last, 2'b01, d, 1'b0);
  endtask

  task automatic pktendCycle(input bit acc);
    if (acc) f2uExpQ.push_back({2'b11, 32'h0});
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 32'h0, 1'b0);
  endtask

  // Read monitor: tracks issued pops through a RD_LATENCY-deep bench delay line
  always @(posedge clk) begin
    if (rst) begin
      tbPipe <= '0;
      rdExpQ.delete();
    end else begin
      tbPipe <= {tbPipe[0], expectPop};
    end
  end

  always @(negedge clk) begin
    if (tbPipe[RDL-1]) begin
      if (rdExpQ.size() == 0) begin
        nTests++; nFail++;
        $display("[TB] FAIL rd_unexpected: got 0x%0h, expected no read", SL_DT_O);
      end else begin
        checkOutput("rd_data", SL_DT_O, rdExpQ.pop_front());
      end
    end
  end

  // F2U monitor: compares every entry the host accepts
  always @(negedge clk) begin
    if (!rst && HF2U_VALID === 1'b1 && HF2U_READY) begin
      f2uPops++;
      if (f2uExpQ.size() == 0) begin
        nTests++; nFail++;
        $display("[TB] FAIL f2u_unexpected: got 0x%0h, expected no entry", HF2U_DATA);
      end else begin
        checkOutput("f2u_entry", {HF2U_ZLP, HF2U_LAST, HF2U_DATA}, f2uExpQ.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    HU2F_VALID = 1'b0; HU2F_DATA = 32'h0; HF2U_READY = 1'b0;
    idle(3);
    @(negedge clk);
    checkOutput("rst_flags", {SL_FLAGA, SL_FLAGB, SL_FLAGC, SL_FLAGD}, 4'b0011);
    checkOutput("rst_dt", {SL_DT_T, SL_DT_O}, 33'h0);
    checkOutput("rst_hready", HU2F_READY, 1'b0);
    checkOutput("rst_hf2u", {HF2U_VALID, HF2U_LAST, HF2U_ZLP}, 3'b000);
    checkOutput("rst_err", {ERR_UNDERRUN, ERR_OVERRUN}, 2'b00);
    rst = 1'b0;
    idle(1);
    @(negedge clk);
    checkOutput("hready_after_rst", HU2F_READY, 1'b1);

    // Read latency
    hostPush(32'h11); hostPush(32'h22); hostPush(32'h33);
    @(negedge clk);
    checkOutput("u2f3_flags_ab", {SL_FLAGA, SL_FLAGB}, 2'b11);
    readCycle(1'b1, 32'h11, 1'b0);
    @(negedge clk);
    checkOutput("dtt_after_oe", SL_DT_T, 1'b1);
    checkOutput("u2f2_flags_ab", {SL_FLAGA, SL_FLAGB}, 2'b11);
    readCycle(1'b1, 32'h22, 1'b0);
    @(negedge clk);
    checkOutput("u2f1_flags_ab", {SL_FLAGA, SL_FLAGB}, 2'b10);
    readCycle(1'b1, 32'h33, 1'b0);
    @(negedge clk);
    checkOutput("u2f0_flaga", {SL_FLAGA, SL_FLAGB}, 2'b00);
    idle(1);
    @(negedge clk);
    checkOutput("dtt_released", SL_DT_T, 1'b0);
    idle(3);
    @(negedge clk);
    checkOutput("dt_held", SL_DT_O, 32'h33);
    checkOutput("no_underrun_yet", ERR_UNDERRUN, 1'b0);

    // Underrun
    readCycle(1'b0, 32'h0, 1'b1);
    idle(1);
    @(negedge clk);
    checkOutput("underrun_set", ERR_UNDERRUN, 1'b1);
    checkOutput("underrun_dt_kept", SL_DT_O, 32'h33);
    checkOutput("underrun_flaga", SL_FLAGA, 1'b0);
    hostPush(32'h44);
    readCycle(1'b1, 32'h44, 1'b1);
    idle(3);
    @(negedge clk);
    checkOutput("no_overrun_yet", ERR_OVERRUN, 1'b0);

    // Write packet plus ZLP
    HF2U_READY = 1'b1;
    popsBefore = f2uPops;
    writeCycle(32'hA0, 1'b0, 1'b1);
    writeCycle(32'hA1, 1'b0, 1'b1);
    writeCycle(32'hA2, 1'b0, 1'b1);
    writeCycle(32'hA3, 1'b1, 1'b1);
    idle(1);
    pktendCycle(1'b1);
    idle(4);
    @(negedge clk);
    checkOutput("pkt_drained", f2uExpQ.size(), 0);
    checkOutput("pkt_pop_count", f2uPops - popsBefore, 5);

    // Full / overrun
    HF2U_READY = 1'b0;
    writeCycle(32'hB0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("f2u1_flags_cd", {SL_FLAGC, SL_FLAGD}, 2'b11);
    writeCycle(32'hB1, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("f2u2_flags_cd", {SL_FLAGC, SL_FLAGD}, 2'b11);
    writeCycle(32'hB2, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("f2u3_flags_cd", {SL_FLAGC, SL_FLAGD}, 2'b10);
    writeCycle(32'hB3, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("f2u4_flags_cd", {SL_FLAGC, SL_FLAGD}, 2'b00);
    checkOutput("overrun_before", ERR_OVERRUN, 1'b0);
    writeCycle(32'hB4, 1'b0, 1'b0);
    idle(1);
    @(negedge clk);
    checkOutput("overrun_set", ERR_OVERRUN, 1'b1);
    checkOutput("full_flags_cd", {SL_FLAGC, SL_FLAGD}, 2'b00);
    checkOutput("fwft_head", {HF2U_VALID, HF2U_DATA}, {1'b1, 32'hB0});
    popsBefore = f2uPops;
    HF2U_READY = 1'b1;
    idle(8);
    @(negedge clk);
    checkOutput("drain_count", f2uPops - popsBefore, 4);
    checkOutput("drain_queue", f2uExpQ.size(), 0);
    checkOutput("drain_empty", {HF2U_VALID, SL_FLAGC, SL_FLAGD}, 3'b011);

    // Simultaneous host push and FPGA pop
    hostPush(32'hC0); hostPush(32'hC1);
    for (int i = 0; i < 10; i++) begin
      HU2F_VALID = 1'b1;
      HU2F_DATA  = 32'hC2 + 32'(i);
      readCycle(1'b1, 32'hC0 + 32'(i), 1'b1);
      @(negedge clk);
      checkOutput("simul_flags_ab", {SL_FLAGA, SL_FLAGB}, 2'b11);
    end
    HU2F_VALID = 1'b0;
    readCycle(1'b1, 32'hCA, 1'b1);
    readCycle(1'b1, 32'hCB, 1'b1);
    idle(3);
    @(negedge clk);
    checkOutput("simul_end_flags", {SL_FLAGA, SL_FLAGB}, 2'b00);
    checkOutput("simul_rd_queue", rdExpQ.size(), 0);

    // Reset in the middle of a read burst
    hostPush(32'hD0); hostPush(32'hD1); hostPush(32'hD2);
    readCycle(1'b1, 32'hD0, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 32'h0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_dtt", SL_DT_T, 1'b0);
    checkOutput("midrst_flags", {SL_FLAGA, SL_FLAGB, SL_FLAGC, SL_FLAGD}, 4'b0011);
    checkOutput("midrst_err", {ERR_UNDERRUN, ERR_OVERRUN}, 2'b00);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      @(negedge clk);
      checkOutput("no_stale_word", SL_DT_O, 32'h0);
    end
    hostPush(32'hE5);
    readCycle(1'b1, 32'hE5, 1'b1);
    idle(3);
    @(negedge clk);
    checkOutput("post_rst_flaga", SL_FLAGA, 1'b0);

    checkOutput("rd_queue_empty", rdExpQ.size(), 0);
    checkOutput("f2u_queue_empty", f2uExpQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
